// File: rtl/gain_control.sv
// Front-panel gain control: synchronises and debounces up/down/mute buttons and
// produces a saturating 4-bit signed amplifier gain code with hold-to-repeat.
module gain_control #(
  parameter int         DEBOUNCE_CYCLES = 500000,
  parameter int         REPEAT_DELAY    = 25000000,
  parameter int         REPEAT_PERIOD   = 5000000,
  parameter logic [3:0] INIT_GAIN       = 4'b0000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_mute,
  output logic [3:0] gain,
  output logic       muted,
  output logic       step
);

  localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX + 1) : 1;

  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  localparam logic signed [3:0] LEVEL_MAX = 4'sd7;
  localparam logic signed [3:0] LEVEL_MIN = -4'sd7;
  localparam logic [3:0]        MUTE_CODE = 4'b1000;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } rpt_state_t;

  // Bit 0 = up, bit 1 = down, bit 2 = mute.
  logic [2:0] btn_raw;
  logic [2:0] stable_vec;
  logic [2:0] stable_prev_reg;
  logic [2:0] press_vec;

  assign btn_raw = {btn_mute, btn_down, btn_up};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_btn
      logic            sync1_reg;
      logic            sync2_reg;
      logic            stable_reg;
      logic [DB_W-1:0] db_cnt_reg;

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          sync1_reg  <= 1'b0;
          sync2_reg  <= 1'b0;
          stable_reg <= 1'b0;
          db_cnt_reg <= '0;
        end else begin
          sync1_reg <= btn_raw[gi];
          sync2_reg <= sync1_reg;
          if (sync2_reg == stable_reg) begin
            db_cnt_reg <= '0;
          end else if (db_cnt_reg == DB_LAST) begin
            // Level has disagreed for DEBOUNCE_CYCLES samples in a row: accept it.
            stable_reg <= sync2_reg;
            db_cnt_reg <= '0;
          end else begin
            db_cnt_reg <= db_cnt_reg + 1'b1;
          end
        end
      end

      assign stable_vec[gi] = stable_reg;
      assign press_vec[gi]  = stable_reg & ~stable_prev_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stable_prev_reg <= '0;
    end else begin
      stable_prev_reg <= stable_vec;
    end
  end

  logic up_stable, down_stable, both_high;
  logic up_press, down_press, mute_press;

  assign up_stable   = stable_vec[0];
  assign down_stable = stable_vec[1];
  assign both_high   = up_stable & down_stable;
  assign up_press    = press_vec[0];
  assign down_press  = press_vec[1];
  assign mute_press  = press_vec[2];

  rpt_state_t       state_reg, state_next;
  logic [RPT_W-1:0] rpt_cnt_reg, rpt_cnt_next;
  logic             dir_up_reg, dir_up_next;
  logic             step_req;
  logic             step_up;
  logic             active_held;
  logic             other_held;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      rpt_cnt_reg <= '0;
      dir_up_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      rpt_cnt_reg <= rpt_cnt_next;
      dir_up_reg  <= dir_up_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    rpt_cnt_next = rpt_cnt_reg;
    dir_up_next  = dir_up_reg;
    step_req     = 1'b0;
    step_up      = dir_up_reg;
    active_held  = dir_up_reg ? up_stable : down_stable;
    other_held   = dir_up_reg ? down_stable : up_stable;

    case (state_reg)
      IDLE: begin
        if (!both_high && (up_press || down_press)) begin
          step_req     = 1'b1;
          step_up      = up_press;
          dir_up_next  = up_press;
          state_next   = DELAY;
          rpt_cnt_next = '0;
        end
      end
      DELAY: begin
        if (!active_held || other_held) begin
          state_next   = IDLE;
          rpt_cnt_next = '0;
        end else if (rpt_cnt_reg == DELAY_LAST) begin
          step_req     = 1'b1;
          state_next   = REPEAT;
          rpt_cnt_next = '0;
        end else begin
          rpt_cnt_next = rpt_cnt_reg + 1'b1;
        end
      end
      REPEAT: begin
        if (!active_held || other_held) begin
          state_next   = IDLE;
          rpt_cnt_next = '0;
        end else if (rpt_cnt_reg == PERIOD_LAST) begin
          step_req     = 1'b1;
          rpt_cnt_next = '0;
        end else begin
          rpt_cnt_next = rpt_cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next   = IDLE;
        rpt_cnt_next = '0;
      end
    endcase
  end

  logic signed [3:0] level_reg, level_next;
  logic              muted_reg, muted_next;
  logic [3:0]        gain_reg, gain_next;
  logic              step_reg, step_next;

  always_comb begin
    level_next = level_reg;
    muted_next = muted_reg;
    step_next  = 1'b0;

    if (mute_press) begin
      // A mute press in the same cycle as a step wins; the step is dropped.
      muted_next = ~muted_reg;
      step_next  = 1'b1;
    end else if (step_req) begin
      if (muted_reg) begin
        muted_next = 1'b0;
        step_next  = 1'b1;
      end else if (step_up) begin
        if (level_reg != LEVEL_MAX) begin
          level_next = level_reg + 4'sd1;
          step_next  = 1'b1;
        end
      end else begin
        if (level_reg != LEVEL_MIN) begin
          level_next = level_reg - 4'sd1;
          step_next  = 1'b1;
        end
      end
    end

    gain_next = muted_next ? MUTE_CODE : level_next;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      level_reg <= INIT_GAIN;
      muted_reg <= 1'b0;
      gain_reg  <= INIT_GAIN;
      step_reg  <= 1'b0;
    end else begin
      level_reg <= level_next;
      muted_reg <= muted_next;
      gain_reg  <= gain_next;
      step_reg  <= step_next;
    end
  end

  assign gain  = gain_reg;
  assign muted = muted_reg;
  assign step  = step_reg;

endmodule

// File: tb/tb_gain_control.sv
// Directed bench for gain_control: latency, repeat cadence, saturation, bounce,
// mute round-trip, unmute-by-step, simultaneous buttons and reset mid-repeat.
module tb_gain_control;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic       clk      = 1'b0;
  logic       reset_n  = 1'b0;
  logic       btn_up   = 1'b0;
  logic       btn_down = 1'b0;
  logic       btn_mute = 1'b0;
  logic [3:0] gain;
  logic       muted;
  logic       step;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gain_control #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP),
    .INIT_GAIN      (4'b0000)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .btn_up  (btn_up),
    .btn_down(btn_down),
    .btn_mute(btn_mute),
    .gain    (gain),
    .muted   (muted),
    .step    (step)
  );

  // Advance n rising edges and settle just after the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    $display("[%0t] %-24s observed=%0h expected=%0h", $time, tag, obs, exp);
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Run n cycles counting step pulses and cycles showing the mute code.
  task automatic watch(input int n, output int pulses, output int mute_codes);
    pulses     = 0;
    mute_codes = 0;
    repeat (n) begin
      tick(1);
      if (step === 1'b1) pulses++;
      if (gain === 4'b1000) mute_codes++;
    end
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    tick(1);
  endtask

  initial begin
    int p;
    int m;
    int total;

    // Reset state
    tick(3);
    check("reset_gain", gain, 4'h0);
    check("reset_muted", muted, 1'b0);
    check("reset_step", step, 1'b0);
    reset_n = 1'b1;
    tick(1);

    // Latency and repeat cadence up to saturation
    btn_up = 1'b1;
    tick(6);
    check("lat_early_gain", gain, 4'h0);
    check("lat_early_step", step, 1'b0);
    tick(1);
    check("lat_gain", gain, 4'h1);
    check("lat_step", step, 1'b1);
    tick(1);
    check("lat_step_width", step, 1'b0);
    tick(18);
    check("delay_hold_gain", gain, 4'h1);
    check("delay_hold_step", step, 1'b0);
    tick(1);
    check("delay_step_gain", gain, 4'h2);
    check("delay_step_step", step, 1'b1);
    for (int lv = 3; lv <= 7; lv++) begin
      tick(RP - 1);
      check("period_gap_step", step, 1'b0);
      tick(1);
      check("period_gain", gain, 32'(lv));
      check("period_step", step, 1'b1);
    end
    watch(30, p, m);
    check("sat_up_pulses", p, 0);
    check("sat_up_gain", gain, 4'h7);
    btn_up = 1'b0;
    tick(10);

    // Bounce rejection, then a real hold of down
    pulse_reset();
    check("rst2_gain", gain, 4'h0);
    total = 0;
    for (int i = 0; i < 8; i++) begin
      btn_down = 1'b1;
      watch(3, p, m);
      total += p;
      btn_down = 1'b0;
      watch(3, p, m);
      total += p;
    end
    check("bounce_pulses", total, 0);
    check("bounce_gain", gain, 4'h0);
    btn_down = 1'b1;
    tick(10);
    check("hold_down_gain", gain, 4'hF);

    // Down saturation, never showing the mute code
    watch(70, p, m);
    check("sat_down_pulses", p, 6);
    check("sat_down_no_mute_code", m, 0);
    check("sat_down_gain", gain, 4'h9);
    btn_down = 1'b0;
    tick(10);

    // Mute round-trip
    btn_mute = 1'b1;
    tick(7);
    check("mute_on_gain", gain, 4'h8);
    check("mute_on_muted", muted, 1'b1);
    check("mute_on_step", step, 1'b1);
    btn_mute = 1'b0;
    watch(10, p, m);
    check("mute_release_pulses", p, 0);
    check("mute_hold_gain", gain, 4'h8);
    btn_mute = 1'b1;
    tick(7);
    check("mute_off_gain", gain, 4'h9);
    check("mute_off_muted", muted, 1'b0);
    check("mute_off_step", step, 1'b1);
    btn_mute = 1'b0;
    tick(10);

    // Unmute via step at level 3
    pulse_reset();
    btn_up = 1'b1;
    tick(7);
    check("unm_lvl1", gain, 4'h1);
    tick(RD);
    check("unm_lvl2", gain, 4'h2);
    tick(RP);
    check("unm_lvl3", gain, 4'h3);
    btn_up = 1'b0;
    watch(12, p, m);
    check("unm_release_pulses", p, 0);
    check("unm_release_gain", gain, 4'h3);
    btn_mute = 1'b1;
    tick(7);
    check("unm_muted_gain", gain, 4'h8);
    check("unm_muted_flag", muted, 1'b1);
    btn_mute = 1'b0;
    tick(10);
    btn_up = 1'b1;
    tick(7);
    check("unm_step_muted", muted, 1'b0);
    check("unm_step_gain", gain, 4'h3);
    check("unm_step_pulse", step, 1'b1);
    btn_up = 1'b0;
    watch(20, p, m);
    check("unm_after_pulses", p, 0);
    check("unm_after_gain", gain, 4'h3);

    // Simultaneous up and down
    pulse_reset();
    btn_up = 1'b1;
    tick(7);
    check("sim_first_gain", gain, 4'h1);
    check("sim_first_step", step, 1'b1);
    tick(15);
    btn_down = 1'b1;
    watch(6, p, m);
    check("sim_pre_lock_pulses", p, 1);
    check("sim_pre_lock_gain", gain, 4'h2);
    watch(40, p, m);
    check("sim_both_pulses", p, 0);
    check("sim_both_gain", gain, 4'h2);
    btn_down = 1'b0;
    watch(40, p, m);
    check("sim_up_only_pulses", p, 0);
    check("sim_up_only_gain", gain, 4'h2);
    btn_up = 1'b0;
    tick(10);
    btn_up = 1'b1;
    tick(7);
    check("sim_repress_gain", gain, 4'h3);
    check("sim_repress_step", step, 1'b1);
    btn_up = 1'b0;
    tick(10);

    // Reset during REPEAT at level 5 with up still held
    pulse_reset();
    btn_up = 1'b1;
    tick(7);
    tick(RD);
    tick(RP);
    tick(RP);
    tick(RP);
    check("rr_level5", gain, 4'h5);
    reset_n = 1'b0;
    tick(1);
    check("rr_gain", gain, 4'h0);
    check("rr_muted", muted, 1'b0);
    check("rr_step", step, 1'b0);
    reset_n = 1'b1;
    tick(6);
    check("rr_early_gain", gain, 4'h0);
    check("rr_early_step", step, 1'b0);
    tick(1);
    check("rr_fresh_gain", gain, 4'h1);
    check("rr_fresh_step", step, 1'b1);
    btn_up = 1'b0;
    tick(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gain_control.md
# gain_control

Converts three raw front-panel push-buttons (up, down, mute) into the 4-bit signed gain code consumed by the amplifier stage directly downstream. Buttons are synchronised and debounced. Up/down step the gain with saturation and hold-to-repeat; mute toggles a forced mute code without losing the stored level. One instance per mixer channel; `gain` wires straight to the amplifier's `gain` input.

## Interface

**Parameters**
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable synchronised samples required to accept a button level change. Minimum 1.
- `REPEAT_DELAY`, default 25000000: cycles a step button must be held after its first step before auto-repeat starts.
- `REPEAT_PERIOD`, default 5000000: cycles between auto-repeat steps.
- `INIT_GAIN`, default 4'b0000: level loaded at reset. Range −7..7 (two's complement). 4'b1000 is not allowed.

**Ports**
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `btn_up` in 1: raw button, active high, asynchronous to `clk`.
- `btn_down` in 1: raw button, active high, asynchronous to `clk`.
- `btn_mute` in 1: raw button, active high, asynchronous to `clk`.
- `gain` out 4: amplifier code. Two's complement −8..7. −8 (4'b1000) means mute; 0 is unity; −7..−1 attenuate; 1..7 boost.
- `muted` out 1: high while mute is engaged.
- `step` out 1: one-cycle pulse on the cycle `gain` takes a new value.

## Operation
- **Synchroniser:** each button passes through two flops.
- **Debouncer, per button:** a stable level register plus a counter.
  - The counter clears whenever the synchronised input equals the stable level.
  - Otherwise it increments. On reaching DEBOUNCE_CYCLES, the stable level flips and the counter clears.
- **Press event:** a stable-level rising edge, one cycle wide. Releases generate no events.
- **Level register:** signed, range −7..7.
  - `gain` = 4'b1000 when `muted` is high, else the level register.
- **Up step:** level +1, saturating at 7. **Down step:** level −1, saturating at −7.
  - A saturated step leaves `gain` unchanged and does not pulse `step`.
- **Step source while muted:** any up/down step clears `muted` and restores the stored level unchanged. This counts as a `gain` change, so `step` pulses.
- **Mute press:** toggles `muted`. `step` pulses.
- **Up and down both stable-high:** no steps; the repeat FSM is forced to IDLE.
- **Mute press in the same cycle as an up/down step:** the mute toggle wins and the step is discarded.
- **Repeat FSM** (one shared counter):
  - IDLE → DELAY on an up or down press event (the step is applied immediately). The counter loads 0.
  - DELAY → REPEAT when the counter reaches REPEAT_DELAY−1, applying one step.
  - REPEAT applies a step each time the counter reaches REPEAT_PERIOD−1, then the counter reloads 0.
  - Any state → IDLE when the active button's stable level drops or the other step button goes stable-high.
  - The direction is latched at the IDLE exit.

## Timing
- **Reset values:** `gain` = INIT_GAIN, `muted` = 0, `step` = 0, all stable levels 0, all counters 0, FSM IDLE, synchroniser flops 0.
- **Button held through reset:** seen as a fresh press, DEBOUNCE_CYCLES + 3 cycles after `reset_n` rises.
- **Press latency:** a raw level change held stable from the cycle-0 sampling edge produces the `gain` update and `step` pulse on edge DEBOUNCE_CYCLES + 3.
  - 2 cycles synchroniser, DEBOUNCE_CYCLES to flip the stable level, 1 cycle to register the output.
- **Bounce:** a glitch shorter than DEBOUNCE_CYCLES produces no event.
- **Repeat cadence:** with a button held, steps occur at the first step, then +REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles.
- **Output timing:** all outputs are registered, with no combinational path from the buttons.
- **Mid-operation reset:** takes effect on the next edge regardless of FSM state.

## Test plan
Parameters for all scenarios: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, INIT_GAIN=0.
- **Latency:** reset, hold `btn_up` → `gain` 0→1 with a one-cycle `step` on edge 7 after assertion; the next step lands 20 cycles later, then every 8 cycles. `gain` stops at 4'b0111 with no further `step` pulses.
- **Bounce rejection:** toggle `btn_down` with 3-cycle pulses for 50 cycles → `gain` stays 0 and `step` stays 0. Then hold 10 cycles → `gain` = 4'b1111.
- **Down saturation and mute round-trip:** hold `btn_down` until saturated → `gain` = 4'b1001, never 4'b1000.
  - Press mute → `gain` = 4'b1000, `muted` = 1.
  - Press mute again → `gain` = 4'b1001, `muted` = 0.
- **Unmute via step:** mute at level 3, then press up → `muted` = 0 and `gain` = 4'b0011 (level not incremented), with one `step` pulse.
- **Simultaneous buttons:** hold up for 15 cycles past its first step, then also assert down → no further steps while both are held, FSM returns to IDLE. Releasing down alone yields no step until up is re-pressed.
- **Reset mid-repeat:** assert `reset_n` low for one cycle during REPEAT at level 5 → `gain` = 0 and `muted` = 0 the next cycle. With up still held, the next step arrives 7 cycles after release of reset.
